pipe_control: RTL

Pipeline sequencer for the five-stage Y86-64 processor. Owns the predicted-PC register and selects the fetch address each cycle. Generates the stall/bubble controls for the F/D/E/M/W pipeline registers and the condition-code write enable. Tracks processor run/halt state and keeps cycle and retired-instruction counters. Sits beside the fetch stage: drives its `f_pc` and consumes its decoded fields.

---
 rtl/y86_pkg.sv | 44 ++++
 rtl/hazard_unit.sv | 42 ++++
 rtl/pipe_control.sv | 122 ++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Y86-64 encodings shared across the pipeline stages: instruction codes,
// the "no register" sentinel, status codes and the pipeline control bundle.
package y86_pkg;

  typedef enum logic [3:0] {
    IHalt  = 4'h0,
    INop   = 4'h1,
    IMrmov = 4'h5,
    IOpq   = 4'h6,
    IJxx   = 4'h7,
    ICall  = 4'h8,
    IRet   = 4'h9,
    IPopq  = 4'hB
  } icode_e;

  localparam logic [3:0] RNone = 4'hF;

  typedef enum logic [1:0] {
    StatAok = 2'd0,
    StatHlt = 2'd1,
    StatIns = 2'd2,
    StatAdr = 2'd3
  } stat_e;

  typedef enum logic [0:0] {
    StRun,
    StHalted
  } run_state_e;

  typedef struct packed {
    logic f_stall;
    logic d_stall;
    logic d_bubble;
    logic e_bubble;
    logic m_bubble;
    logic w_stall;
    logic set_cc;
  } pipe_ctrl_t;

  function automatic logic is_load(input logic [3:0] icode);
    return (icode == IMrmov) || (icode == IPopq);
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Combinational hazard detection: load-use, pending return and branch mispredict,
// folded into the raw pipeline register controls used while running.
module hazard_unit
  import y86_pkg::*;
(
  input  logic [3:0] d_icode_i,
  input  logic [3:0] e_icode_i,
  input  logic [3:0] e_dstm_i,
  input  logic [3:0] d_srca_i,
  input  logic [3:0] d_srcb_i,
  input  logic [3:0] m_icode_i,
  input  logic       e_cnd_i,
  input  logic [1:0] m_stat_i,
  input  logic [1:0] w_stat_i,
  output pipe_ctrl_t ctrl_o
);

  logic load_use;
  logic ret_pend;
  logic mispred;
  logic m_exc;
  logic w_exc;

  assign load_use = is_load(e_icode_i) && (e_dstm_i != RNone) &&
                    ((e_dstm_i == d_srca_i) || (e_dstm_i == d_srcb_i));
  assign ret_pend = (d_icode_i == IRet) || (e_icode_i == IRet) || (m_icode_i == IRet);
  assign mispred  = (e_icode_i == IJxx) && !e_cnd_i;
  assign m_exc    = (m_stat_i != StatAok);
  assign w_exc    = (w_stat_i != StatAok);

  always_comb begin
    ctrl_o.f_stall  = load_use | ret_pend;
    ctrl_o.d_stall  = load_use;
    // A load-use stall in D outranks the return bubble.
    ctrl_o.d_bubble = mispred | (!load_use & ret_pend);
    ctrl_o.e_bubble = mispred | load_use;
    ctrl_o.m_bubble = m_exc | w_exc;
    ctrl_o.w_stall  = w_exc;
    ctrl_o.set_cc   = (e_icode_i == IOpq) & !m_exc & !w_exc;
  end

endmodule

// File: rtl/pipe_control.sv
// Y86-64 pipeline sequencer: fetch PC selection, predicted-PC register,
// run/halt state, and cycle / retired-instruction counters.
module pipe_control
  import y86_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [3:0]       f_icode,
  input  logic [63:0]      f_valc,
  input  logic [63:0]      f_valp,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstm,
  input  logic             e_cnd,
  input  logic [3:0]       d_srca,
  input  logic [3:0]       d_srcb,
  input  logic [3:0]       M_icode,
  input  logic             M_cnd,
  input  logic [63:0]      M_vala,
  input  logic [1:0]       m_stat,
  input  logic [1:0]       W_stat,
  input  logic [3:0]       W_icode,
  input  logic [63:0]      W_valm,
  output logic [63:0]      f_pc,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  run_state_e       state_q;
  logic [63:0]      pred_pc_q;
  logic [63:0]      pred_pc_d;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instr_q;
  logic             retire;
  pipe_ctrl_t       ctrl_raw;
  pipe_ctrl_t       ctrl;

  hazard_unit u_hazard (
    .d_icode_i (D_icode),
    .e_icode_i (E_icode),
    .e_dstm_i  (E_dstm),
    .d_srca_i  (d_srca),
    .d_srcb_i  (d_srcb),
    .m_icode_i (M_icode),
    .e_cnd_i   (e_cnd),
    .m_stat_i  (m_stat),
    .w_stat_i  (W_stat),
    .ctrl_o    (ctrl_raw)
  );

  // Once halted the whole pipe is frozen: stall everything, keep M empty.
  always_comb begin
    ctrl = ctrl_raw;
    if (state_q == StHalted) begin
      ctrl.f_stall  = 1'b1;
      ctrl.d_stall  = 1'b1;
      ctrl.d_bubble = 1'b0;
      ctrl.e_bubble = 1'b0;
      ctrl.m_bubble = 1'b1;
      ctrl.w_stall  = 1'b1;
      ctrl.set_cc   = 1'b0;
    end
  end

  assign F_stall  = ctrl.f_stall;
  assign D_stall  = ctrl.d_stall;
  assign D_bubble = ctrl.d_bubble;
  assign E_bubble = ctrl.e_bubble;
  assign M_bubble = ctrl.m_bubble;
  assign W_stall  = ctrl.w_stall;
  assign set_cc   = ctrl.set_cc;

  always_comb begin
    if ((M_icode == IJxx) && !M_cnd) begin
      f_pc = M_vala;
    end else if (W_icode == IRet) begin
      f_pc = W_valm;
    end else begin
      f_pc = pred_pc_q;
    end
  end

  assign pred_pc_d = ((f_icode == IJxx) || (f_icode == ICall)) ? f_valc : f_valp;
  assign retire    = (W_stat == StatAok) && (W_icode != INop) && !ctrl.w_stall;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StRun;
      pred_pc_q <= 64'd0;
      cycle_q   <= '0;
      instr_q   <= '0;
    end else begin
      if (!ctrl.f_stall) begin
        pred_pc_q <= pred_pc_d;
      end
      if (state_q == StRun) begin
        cycle_q <= cycle_q + CNT_W'(1);
        if (retire) begin
          instr_q <= instr_q + CNT_W'(1);
        end
        if (W_stat != StatAok) begin
          state_q <= StHalted;
        end
      end
    end
  end

  assign halted      = (state_q == StHalted);
  assign cycle_count = cycle_q;
  assign instr_count = instr_q;

endmodule
